// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit:
// state enum, opcodes, control-field encodings, per-state control word.
package main_fsm_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECR,
      ALUWB,
      EXECI,
      JAL,
      BEQ
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Moore control word. gated marks enables that only fire
   // in the cycle memory reports ready (IRWrite/PCUpdate in FETCH).
   typedef struct packed {
      logic       mem_req;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       pcupdate;
      logic       gated;
      logic       branch;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
   } ctl_t;

   function automatic ctl_t ctl_of(input state_t s);
      ctl_t c;
      c = '0;
      unique case (s)
         FETCH: begin
            c.mem_req   = 1'b1;
            c.irwrite   = 1'b1;
            c.pcupdate  = 1'b1;
            c.gated     = 1'b1;
            c.alusrca   = SRCA_PC;
            c.alusrcb   = SRCB_FOUR;
            c.aluop     = ALU_ADD;
            c.resultsrc = RES_ALURES;
         end
         DECODE: begin
            c.alusrca = SRCA_OLDPC;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALU_ADD;
         end
         MEMADR: begin
            c.alusrca = SRCA_RS1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALU_ADD;
         end
         MEMREAD: begin
            c.mem_req   = 1'b1;
            c.adrsrc    = 1'b1;
            c.resultsrc = RES_ALUOUT;
         end
         MEMWB: begin
            c.resultsrc = RES_RDATA;
            c.regwrite  = 1'b1;
         end
         MEMWRITE: begin
            c.mem_req   = 1'b1;
            c.adrsrc    = 1'b1;
            c.memwrite  = 1'b1;
            c.resultsrc = RES_ALUOUT;
         end
         EXECR: begin
            c.alusrca = SRCA_RS1;
            c.alusrcb = SRCB_RS2;
            c.aluop   = ALU_FUNCT;
         end
         EXECI: begin
            c.alusrca = SRCA_RS1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALU_FUNCT;
         end
         ALUWB: begin
            c.resultsrc = RES_ALUOUT;
            c.regwrite  = 1'b1;
         end
         JAL: begin
            c.alusrca   = SRCA_OLDPC;
            c.alusrcb   = SRCB_FOUR;
            c.aluop     = ALU_ADD;
            c.resultsrc = RES_ALUOUT;
            c.pcupdate  = 1'b1;
         end
         BEQ: begin
            c.alusrca   = SRCA_RS1;
            c.alusrcb   = SRCB_RS2;
            c.aluop     = ALU_SUB;
            c.resultsrc = RES_ALUOUT;
            c.branch    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/main_fsm_op_classify.sv
// Opcode classifier: immediate format and legality of an opcode.
// Ports: op in; immsrc (I/S/B/J), illegal out. Purely combinational.
module op_classify
   import main_fsm_pkg::*;
#(
   parameter bit ENABLE_ITYPE = 1'b1,
   parameter bit ENABLE_JAL   = 1'b1
) (
   input  logic [6:0] op,
   output logic [1:0] immsrc,
   output logic       illegal
);

   always_comb begin
      immsrc  = IMM_I;
      illegal = 1'b1;
      unique case (1'b1)
         (op == OP_LOAD): begin
            immsrc  = IMM_I;
            illegal = 1'b0;
         end
         (op == OP_STORE): begin
            immsrc  = IMM_S;
            illegal = 1'b0;
         end
         (op == OP_RTYPE): begin
            immsrc  = IMM_I;
            illegal = 1'b0;
         end
         (op == OP_ITYPE): begin
            immsrc  = IMM_I;
            illegal = !ENABLE_ITYPE;
         end
         (op == OP_JAL): begin
            immsrc  = IMM_J;
            illegal = !ENABLE_JAL;
         end
         (op == OP_BRANCH): begin
            immsrc  = IMM_B;
            illegal = 1'b0;
         end
         default: begin
            immsrc  = IMM_I;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM with ready-handshaked memory access.
// Ports: clk, reset, op, zero, mem_ready in; memory/PC/IR/RF enables,
// mux selects, ALUOp, ImmSrc and illegal out.
module main_fsm
   import main_fsm_pkg::*;
#(
   parameter bit ENABLE_ITYPE = 1'b1,
   parameter bit ENABLE_JAL   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       illegal
);

   state_t state;
   state_t nxt;
   ctl_t   ctl;
   logic   cls_illegal;
   logic   fire;

   op_classify #(
      .ENABLE_ITYPE (ENABLE_ITYPE),
      .ENABLE_JAL   (ENABLE_JAL)
   ) u_cls (
      .op      (op),
      .immsrc  (ImmSrc),
      .illegal (cls_illegal)
   );

   always_comb begin
      nxt = state;
      unique case (state)
         FETCH:    nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            if (cls_illegal) begin
               nxt = FETCH;
            end else begin
               unique case (1'b1)
                  (op == OP_LOAD),
                  (op == OP_STORE):  nxt = MEMADR;
                  (op == OP_RTYPE):  nxt = EXECR;
                  (op == OP_ITYPE):  nxt = EXECI;
                  (op == OP_JAL):    nxt = JAL;
                  (op == OP_BRANCH): nxt = BEQ;
                  default:           nxt = FETCH;
               endcase
            end
         end
         MEMADR:   nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
         MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
         MEMWB:    nxt = FETCH;
         MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
         EXECR:    nxt = ALUWB;
         EXECI:    nxt = ALUWB;
         ALUWB:    nxt = FETCH;
         JAL:      nxt = ALUWB;
         BEQ:      nxt = FETCH;
         default:  nxt = FETCH;
      endcase
   end

   // Control word is registered from the next state so that every
   // Moore output comes straight off a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         ctl   <= ctl_of(FETCH);
      end else begin
         state <= nxt;
         ctl   <= ctl_of(nxt);
      end
   end

   // Gated enables fire only in the handshake cycle.
   assign fire = ~ctl.gated | mem_ready;

   assign mem_req   = ~reset & ctl.mem_req;
   assign MemWrite  = ~reset & ctl.memwrite;
   assign IRWrite   = ~reset & ctl.irwrite & fire;
   assign RegWrite  = ~reset & ctl.regwrite;
   assign PCWrite   = ~reset & ((ctl.pcupdate & fire) | (ctl.branch & zero));
   assign illegal   = ~reset & (state == DECODE) & cls_illegal;
   assign AdrSrc    = ctl.adrsrc;
   assign ResultSrc = ctl.resultsrc;
   assign ALUSrcA   = ctl.alusrca;
   assign ALUSrcB   = ctl.alusrcb;
   assign ALUOp     = ctl.aluop;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-cycle control vectors per state,
// wait states, beq zero, illegal ops and reset during a store.
module tb_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;

   logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic       illegal;

   logic       mem_req2, PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2;
   logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2, ImmSrc2;
   logic       illegal2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   main_fsm dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
      .illegal(illegal)
   );

   main_fsm #(.ENABLE_JAL(1'b0)) dut2 (
      .clk(clk), .reset(reset), .op(op), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req2), .PCWrite(PCWrite2),
      .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
      .RegWrite(RegWrite2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2),
      .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .ImmSrc(ImmSrc2),
      .illegal(illegal2)
   );

   // {pad, mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
   //  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal}
   logic [15:0] v1, v2;
   assign v1 = {1'b0, mem_req, PCWrite, AdrSrc, MemWrite, IRWrite,
                RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};
   assign v2 = {1'b0, mem_req2, PCWrite2, AdrSrc2, MemWrite2, IRWrite2,
                RegWrite2, ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2, illegal2};

   localparam logic [15:0] F_WAIT  = 16'b0_1_0_0_0_0_0_10_00_10_00_0;
   localparam logic [15:0] F_RDY   = 16'b0_1_1_0_0_1_0_10_00_10_00_0;
   localparam logic [15:0] RST     = 16'b0_0_0_0_0_0_0_10_00_10_00_0;
   localparam logic [15:0] DEC     = 16'b0_0_0_0_0_0_0_00_01_01_00_0;
   localparam logic [15:0] DEC_IL  = 16'b0_0_0_0_0_0_0_00_01_01_00_1;
   localparam logic [15:0] MADR    = 16'b0_0_0_0_0_0_0_00_10_01_00_0;
   localparam logic [15:0] MRD     = 16'b0_1_0_1_0_0_0_00_00_00_00_0;
   localparam logic [15:0] MWB     = 16'b0_0_0_0_0_0_1_01_00_00_00_0;
   localparam logic [15:0] MWR     = 16'b0_1_0_1_1_0_0_00_00_00_00_0;
   localparam logic [15:0] MWR_RST = 16'b0_0_0_1_0_0_0_00_00_00_00_0;
   localparam logic [15:0] EXR     = 16'b0_0_0_0_0_0_0_00_10_00_10_0;
   localparam logic [15:0] EXI     = 16'b0_0_0_0_0_0_0_00_10_01_10_0;
   localparam logic [15:0] AWB     = 16'b0_0_0_0_0_0_1_00_00_00_00_0;
   localparam logic [15:0] JALV    = 16'b0_0_1_0_0_0_0_00_01_10_00_0;
   localparam logic [15:0] BEQ1    = 16'b0_0_1_0_0_0_0_00_10_00_01_0;
   localparam logic [15:0] BEQ0    = 16'b0_0_0_0_0_0_0_00_10_00_01_0;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of the default instance: drive ready, check, advance.
   task automatic cyc(input logic rdy, input logic [15:0] exp,
                      input string tag);
      mem_ready = rdy;
      #1;
      chk(tag, v1, exp);
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      op        = 7'b0000000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      tick();
      tick();
      chk("rst_vec", v1, RST);
      chk("rst_vec2", v2, RST);

      // lw with two FETCH waits and one MEMREAD wait
      op    = 7'b0000011;
      reset = 1'b0;
      cyc(1'b0, F_WAIT, "lw_f0");
      cyc(1'b0, F_WAIT, "lw_f1");
      cyc(1'b1, F_RDY,  "lw_f2");
      chk("lw_imm", {14'd0, ImmSrc}, 16'd0);
      cyc(1'b1, DEC,    "lw_dec");
      cyc(1'b1, MADR,   "lw_madr");
      cyc(1'b0, MRD,    "lw_mrd0");
      cyc(1'b1, MRD,    "lw_mrd1");
      // eighth cycle after release
      cyc(1'b1, MWB,    "lw_wb");

      // sw, no waits
      op = 7'b0100011;
      cyc(1'b1, F_RDY, "sw_f");
      chk("sw_imm", {14'd0, ImmSrc}, 16'd1);
      cyc(1'b1, DEC,   "sw_dec");
      cyc(1'b1, MADR,  "sw_madr");
      cyc(1'b1, MWR,   "sw_mwr");

      // beq taken then not taken
      op   = 7'b1100011;
      zero = 1'b1;
      cyc(1'b1, F_RDY, "beq1_f");
      chk("beq_imm", {14'd0, ImmSrc}, 16'd2);
      cyc(1'b1, DEC,   "beq1_dec");
      cyc(1'b1, BEQ1,  "beq1_ex");
      zero = 1'b0;
      cyc(1'b1, F_RDY, "beq0_f");
      cyc(1'b1, DEC,   "beq0_dec");
      cyc(1'b1, BEQ0,  "beq0_ex");

      // add, addi, jal back-to-back
      op = 7'b0110011;
      cyc(1'b1, F_RDY, "add_f");
      cyc(1'b1, DEC,   "add_dec");
      cyc(1'b1, EXR,   "add_ex");
      cyc(1'b1, AWB,   "add_wb");
      op = 7'b0010011;
      cyc(1'b1, F_RDY, "addi_f");
      chk("addi_imm", {14'd0, ImmSrc}, 16'd0);
      cyc(1'b1, DEC,   "addi_dec");
      cyc(1'b1, EXI,   "addi_ex");
      cyc(1'b1, AWB,   "addi_wb");
      op = 7'b1101111;
      cyc(1'b1, F_RDY, "jal_f");
      chk("jal_imm", {14'd0, ImmSrc}, 16'd3);
      cyc(1'b1, DEC,   "jal_dec");
      cyc(1'b1, JALV,  "jal_ex");
      cyc(1'b1, AWB,   "jal_wb");

      // unsupported opcode at defaults
      op = 7'b1111111;
      cyc(1'b1, F_RDY,  "ill_f");
      cyc(1'b1, DEC_IL, "ill_dec");
      cyc(1'b0, F_WAIT, "ill_next");

      // jal on the ENABLE_JAL=0 instance
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      op        = 7'b1101111;
      mem_ready = 1'b1;
      #1;
      chk("j2_f", v2, F_RDY);
      tick();
      chk("j2_dec", v2, DEC_IL);
      mem_ready = 1'b0;
      tick();
      chk("j2_next", v2, F_WAIT);

      // reset while MEMWRITE is waiting
      reset = 1'b1;
      tick();
      reset = 1'b0;
      op    = 7'b0100011;
      cyc(1'b1, F_RDY, "rs_f");
      cyc(1'b1, DEC,   "rs_dec");
      cyc(1'b1, MADR,  "rs_madr");
      mem_ready = 1'b0;
      #1;
      chk("rs_mwr", v1, MWR);
      reset = 1'b1;
      #1;
      chk("rs_mwr_rst", v1, MWR_RST);
      tick();
      chk("rs_hold", v1, RST);
      reset = 1'b0;
      cyc(1'b0, F_WAIT, "rs_rel");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
